// File: rtl/sseg_display_ctrl.sv
// sseg_display_ctrl: converts a signed value to BCD (sequential double-dabble) and
// posts one digit write per cycle to sseg_array, applying minus-sign placement,
// decimal point and overflow dashes.
// Build option: SSEG_CTRL_LZB_EN -- when defined, leading zeros are blanked and the
// minus sign sits just left of the highest shown digit; when undefined, every digit
// is shown and the sign occupies the leftmost digit.
module sseg_display_ctrl #(
    parameter int unsigned SSEG_BITS = 2,
    parameter int unsigned SSEG_N    = 4,
    parameter int unsigned DATA_BITS = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] value,
    input  logic                 dp_en,
    input  logic [SSEG_BITS-1:0] dp_pos,
    output logic                 ready,
    output logic                 done_tick,
    output logic                 overflow,
    output logic                 wr,
    output logic [SSEG_BITS-1:0] sel,
    output logic [3:0]           val,
    output logic                 en,
    output logic                 sign,
    output logic                 dp
);
    localparam int unsigned BCD_W   = 4 * SSEG_N;
    localparam int unsigned TOP_W   = SSEG_BITS + 1;
    localparam int unsigned CNT_MAX = (DATA_BITS > SSEG_N) ? DATA_BITS : SSEG_N;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int unsigned MAG_MAX = 10 ** SSEG_N - 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CONV  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Add 3 to every BCD digit that is 5 or more (pre-shift correction).
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int d = 0; d < int'(SSEG_N); d++)
            if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
        return r;
    endfunction

    // Index of the highest nonzero BCD digit, 0 when all digits are zero.
    function automatic logic [SSEG_BITS-1:0] msnz_of(input logic [BCD_W-1:0] b);
        logic [SSEG_BITS-1:0] m;
        m = '0;
        for (int d = 0; d < int'(SSEG_N); d++)
            if (b[4*d +: 4] != 4'd0) m = SSEG_BITS'(d);
        return m;
    endfunction

    logic [2:0]           state_r, state_n;
    logic [DATA_BITS-1:0] value_r, value_n;
    logic                 dp_en_r, dp_en_n;
    logic [SSEG_BITS-1:0] dp_pos_r, dp_pos_n;
    logic                 neg_r, neg_n;
    logic                 ovf_r, ovf_n;
    logic [DATA_BITS-1:0] bin_r, bin_n;
    logic [BCD_W-1:0]     bcd_r, bcd_n;
    logic [CNT_W-1:0]     cnt_r, cnt_n;
`ifdef SSEG_CTRL_LZB_EN
    logic [SSEG_BITS-1:0] top_r, top_n, top_c;
`endif

    logic                 ready_n, done_n, overflow_n, wr_n, en_n, sign_n, dp_n;
    logic [SSEG_BITS-1:0] sel_n;
    logic [3:0]           val_n;
    logic [TOP_W-1:0]     k;

    logic [DATA_BITS-1:0] mag;
    logic [BCD_W-1:0]     bcd_step;
    logic [DATA_BITS-1:0] bin_step;
    logic [SSEG_BITS-1:0] msnz;
    logic                 neg_ovf;

    // Double-dabble datapath and end-of-conversion digit analysis.
    assign mag      = value_r[DATA_BITS-1] ? (~value_r + DATA_BITS'(1)) : value_r;
    assign bcd_step = (add3(bcd_r) << 1) | BCD_W'(bin_r[DATA_BITS-1]);
    assign bin_step = bin_r << 1;
    assign msnz     = msnz_of(bcd_step);
`ifdef SSEG_CTRL_LZB_EN
    assign top_c    = (dp_en_r && (dp_pos_r > msnz)) ? dp_pos_r : msnz;
    assign neg_ovf  = neg_r && ((TOP_W'(top_c) + TOP_W'(1)) > TOP_W'(SSEG_N - 1));
`else
    assign neg_ovf  = neg_r && ((TOP_W'(msnz) + TOP_W'(1)) > TOP_W'(SSEG_N - 1));
`endif

    // Next-state, datapath and next-output logic; outputs follow the next state.
    always_comb begin
        state_n    = state_r;
        value_n    = value_r;
        dp_en_n    = dp_en_r;
        dp_pos_n   = dp_pos_r;
        neg_n      = neg_r;
        ovf_n      = ovf_r;
        bin_n      = bin_r;
        bcd_n      = bcd_r;
        cnt_n      = cnt_r;
`ifdef SSEG_CTRL_LZB_EN
        top_n      = top_r;
`endif
        overflow_n = overflow;
        ready_n    = 1'b0;
        done_n     = 1'b0;
        wr_n       = 1'b0;
        sel_n      = '0;
        val_n      = 4'd0;
        en_n       = 1'b0;
        sign_n     = 1'b0;
        dp_n       = 1'b0;
        k          = '0;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    value_n    = value;
                    dp_en_n    = dp_en;
                    dp_pos_n   = dp_pos;
                    overflow_n = 1'b0;
                    state_n    = S_LOAD;
                end
            end
            S_LOAD: begin
                neg_n = value_r[DATA_BITS-1];
                bin_n = mag;
                bcd_n = '0;
                cnt_n = '0;
                ovf_n = 1'b0;
                if (32'(mag) > MAG_MAX) begin
                    ovf_n   = 1'b1;
                    cnt_n   = CNT_W'(SSEG_N - 1);
                    state_n = S_WRITE;
                end else begin
                    state_n = S_CONV;
                end
            end
            S_CONV: begin
                bcd_n = bcd_step;
                bin_n = bin_step;
                cnt_n = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(DATA_BITS - 1)) begin
                    ovf_n   = neg_ovf;
`ifdef SSEG_CTRL_LZB_EN
                    top_n   = top_c;
`endif
                    cnt_n   = CNT_W'(SSEG_N - 1);
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt_r == '0) state_n = S_DONE;
                else             cnt_n   = cnt_r - CNT_W'(1);
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        ready_n = (state_n == S_IDLE);
        if (state_n == S_DONE) begin
            done_n     = 1'b1;
            overflow_n = ovf_n;
        end
        if (state_n == S_WRITE) begin
            k     = TOP_W'(cnt_n);
            wr_n  = 1'b1;
            sel_n = SSEG_BITS'(cnt_n);
            if (ovf_n) begin
                en_n   = 1'b1;
                sign_n = 1'b1;
            end else begin
                for (int d = 0; d < int'(SSEG_N); d++)
                    if (TOP_W'(d) == k) val_n = bcd_n[4*d +: 4];
`ifdef SSEG_CTRL_LZB_EN
                en_n   = (k <= TOP_W'(top_n)) ||
                         (neg_n && (k == TOP_W'(top_n) + TOP_W'(1)));
                sign_n = neg_n && (k == TOP_W'(top_n) + TOP_W'(1));
`else
                en_n   = 1'b1;
                sign_n = neg_n && (k == TOP_W'(SSEG_N - 1));
`endif
                dp_n   = dp_en_n && (k == TOP_W'(dp_pos_n));
            end
        end
    end

    // State, datapath and registered outputs; reset aborts immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            value_r   <= '0;
            dp_en_r   <= 1'b0;
            dp_pos_r  <= '0;
            neg_r     <= 1'b0;
            ovf_r     <= 1'b0;
            bin_r     <= '0;
            bcd_r     <= '0;
            cnt_r     <= '0;
`ifdef SSEG_CTRL_LZB_EN
            top_r     <= '0;
`endif
            ready     <= 1'b1;
            done_tick <= 1'b0;
            overflow  <= 1'b0;
            wr        <= 1'b0;
            sel       <= '0;
            val       <= 4'd0;
            en        <= 1'b0;
            sign      <= 1'b0;
            dp        <= 1'b0;
        end else begin
            state_r   <= state_n;
            value_r   <= value_n;
            dp_en_r   <= dp_en_n;
            dp_pos_r  <= dp_pos_n;
            neg_r     <= neg_n;
            ovf_r     <= ovf_n;
            bin_r     <= bin_n;
            bcd_r     <= bcd_n;
            cnt_r     <= cnt_n;
`ifdef SSEG_CTRL_LZB_EN
            top_r     <= top_n;
`endif
            ready     <= ready_n;
            done_tick <= done_n;
            overflow  <= overflow_n;
            wr        <= wr_n;
            sel       <= sel_n;
            val       <= val_n;
            en        <= en_n;
            sign      <= sign_n;
            dp        <= dp_n;
        end
    end

endmodule
